gost89_ofb_sched: RTL and testbench
===================================

GOST89_OFB_SCHED -- requirements
Module: gost89_ofb_sched

Interface
REQ-001 SHALL have no parameters; the keystream buffer depth is fixed at 2.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 load_IV  in  1  one-cycle pulse: restart the stream with the value on IV.
REQ-005 IV  in  64  initial OFB register value, sampled when load_IV=1.
REQ-006 in_valid / in_ready / in_data  in / out / in  1/1/64  plaintext (or ciphertext) input handshake.
REQ-007 out_valid / out_ready / out_data  out / in / out  1/1/64  result output handshake.
REQ-008 core_start  out  1  one-cycle start pulse to the shared gost89 ECB encrypt core.
REQ-009 core_in  out  64  core input block, valid while core_start=1.
REQ-010 core_out / core_busy  in / in  64/1  core result and busy flag; the result is valid in the first cycle core_busy=0 after core_busy=1.
REQ-011 iv_loaded  out  1  high once an IV has been accepted since reset.
REQ-012 blk_cnt  out  32  number of output blocks accepted since the last load_IV.

Function
REQ-013 SHALL generate the OFB keystream S1=E(IV) and Si=E(Si-1), and emit out_data = in_data XOR Si for the i-th accepted input block.
REQ-014 Core FSM states SHALL be IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN transition: iv_loaded=1 and the keystream buffer holds fewer than 2 entries. The FSM pulses core_start with core_in = last keystream block, or IV for the first block.
REQ-016 RUN->IDLE transition: on core completion, core_out SHALL be pushed into the buffer and retained as the next feedback value.
REQ-017 Keystream buffer SHALL be a 2-entry FIFO, so that generation of Si+1 overlaps the consumption of Si.
REQ-018 in_ready SHALL equal (buffer not empty) AND (out_valid=0 OR out_ready=1) AND load_IV=0.
REQ-019 On an input transfer, out_data SHALL register the XOR result one cycle later with out_valid=1, the buffer head SHALL pop, and blk_cnt SHALL increment.
REQ-020 out_valid SHALL hold, with out_data stable, until out_ready=1; back-to-back transfers SHALL sustain one block per cycle while the buffer is non-empty.
REQ-021 When load_IV=1 in IDLE: flush the buffer, clear blk_cnt, latch IV, and set iv_loaded.
REQ-022 When load_IV=1 in RUN: additionally enter DRAIN. The pending core result SHALL be discarded on completion, then the FSM returns to IDLE and restarts from the new IV.
REQ-023 When load_IV and an input transfer coincide, load_IV SHALL win and no input SHALL be accepted, because in_ready=0.
REQ-024 A pending out_valid word SHALL survive load_IV unchanged.
REQ-025 blk_cnt SHALL wrap from FFFFFFFF to 0.
REQ-026 The block SHALL never pulse core_start while core_busy=1 or in the completion cycle.
REQ-027 With iv_loaded=0, in_ready SHALL be 0 and no core_start SHALL be issued.

Reset
REQ-028 Reset SHALL asynchronously force the FSM to IDLE and clear the buffer.
REQ-029 Reset SHALL set out_valid=0, out_data=0, core_start=0, core_in=0, iv_loaded=0 and blk_cnt=0.
REQ-030 Reset asserted mid-RUN SHALL cause the in-flight core result to be ignored; the core itself is reset by the same net.
REQ-031 After reset release, a new load_IV SHALL be required before any input is accepted.

Structure
REQ-032 A shared package gost89_pkg SHALL hold the 64-bit block type, the FSM state enum and the buffer depth constant (2).
REQ-033 The keystream FIFO SHALL be the sub-module gost89_ks_fifo (2x64, push/pop/flush/count); the XOR and handshake logic stays in the top.

Verification
REQ-034 Key 0475f6e0...d2bcefbd, load_IV with IV=d5a8a608f4f115b4, then eight in_data=0 blocks -> out_data equals the gost89 golden-model keystream S1..S8, and blk_cnt=8.
REQ-035 Ciphertext from REQ-034 fed back in after reloading the same IV -> out_data=0 for all eight blocks (decryption round trip).
REQ-036 out_ready held 0 for 100 cycles with in_valid=1 -> exactly one output held stable, buffer full at 2, and no core_start while full.
REQ-037 load_IV with IV=0123456789abcdef issued 12 cycles into a core run -> the in-flight result is dropped, and the first output after the reload equals in XOR E(0123456789abcdef).
REQ-038 reset pulsed low mid-run, then load_IV=d5a8a608f4f115b4 -> all outputs zero during reset, and the stream restarts at S1 of REQ-034.
REQ-039 Inputs presented with no prior IV, then blk_cnt preset near FFFFFFFE via a long run -> in_ready=0 before the IV is loaded, and blk_cnt wraps to 0 without disturbing the stream.

Source files
------------

// File: rtl/gost89_pkg.sv
// Shared types and constants for the GOST 28147-89 OFB keystream scheduler.
package gost89_pkg;

    // One cipher block; also one keystream word.
    typedef logic [63:0] block_t;

    // Keystream buffer depth and the width of its occupancy count (0..2).
    localparam int KS_DEPTH = 2;
    localparam int KS_CNT_W = 2;

    // Scheduler FSM that owns the shared ECB core.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } core_state_e;

    // OFB combine step: data word XOR keystream word.
    function automatic block_t ofb_xor(input block_t data, input block_t ks);
        return data ^ ks;
    endfunction

endpackage

// File: rtl/gost89_ks_fifo.sv
// Two-entry keystream FIFO. Pointers are one bit wide because the depth is
// fixed at two; flush has priority over push and pop in the same cycle.
module gost89_ks_fifo
    import gost89_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic [63:0]         push_data_i,
    input  logic                pop_i,
    output logic [63:0]         head_o,
    output logic [KS_CNT_W-1:0] count_o
);

    block_t              mem_q [KS_DEPTH];
    block_t              mem_d [KS_DEPTH];
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [KS_CNT_W-1:0] count_q, count_d;
    logic                empty, full;
    logic                do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == KS_CNT_W'(KS_DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop   = pop_i && !empty;
        do_push  = push_i && (!full || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < KS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gost89_ofb_sched.sv
// OFB keystream scheduler around a shared GOST 28147-89 ECB encrypt core.
// The core is fed S(i-1) (or the IV) to produce S(i); up to two keystream
// words are buffered so generation overlaps consumption. Each accepted input
// word is XORed with the buffer head into a registered output.
//
// Handshake: a word moves on a rising edge where valid and ready are both 1.
// in_ready never depends on in_valid; out_valid, once raised, holds with
// out_data stable until the edge where out_ready=1.
module gost89_ofb_sched
    import gost89_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_IV,
    input  logic [63:0] IV,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        core_start,
    output logic [63:0] core_in,
    input  logic [63:0] core_out,
    input  logic        core_busy,
    output logic        iv_loaded,
    output logic [31:0] blk_cnt,
    output logic [1:0]  dbg_state
);

    core_state_e         state_q, state_d;
    logic                busy_prev_q;
    logic                core_done;
    block_t              fb_q, fb_d;
    logic                core_start_q, core_start_d;
    block_t              core_in_q, core_in_d;
    logic                iv_loaded_q, iv_loaded_d;
    logic [31:0]         blk_cnt_q, blk_cnt_d;
    logic                out_valid_q, out_valid_d;
    block_t              out_data_q, out_data_d;
    logic                ks_push, ks_pop;
    block_t              ks_head;
    logic [KS_CNT_W-1:0] ks_count;
    logic                ks_empty, ks_full;
    logic                in_xfer;

    gost89_ks_fifo u_ks_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .flush_i     (load_IV),
        .push_i      (ks_push),
        .push_data_i (core_out),
        .pop_i       (ks_pop),
        .head_o      (ks_head),
        .count_o     (ks_count)
    );

    // The core result is valid in the first cycle busy falls after being high.
    assign core_done = busy_prev_q && !core_busy;
    assign ks_full   = (ks_count == KS_CNT_W'(KS_DEPTH));
    assign ks_empty  = (ks_count == '0);

    // load_IV blocks input so a reload can never race a consumed word.
    assign in_ready = iv_loaded_q && !ks_empty && (!out_valid_q || out_ready) && !load_IV;
    assign in_xfer  = in_valid && in_ready;
    assign ks_pop   = in_xfer;

    assign core_start = core_start_q;
    assign core_in    = core_in_q;
    assign iv_loaded  = iv_loaded_q;
    assign blk_cnt    = blk_cnt_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign dbg_state  = state_q;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start when there is room, drain a stale run on reload.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!load_IV && iv_loaded_q && !ks_full) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_IV) begin
                    state_d = core_done ? ST_IDLE : ST_DRAIN;
                end else if (core_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (core_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: start pulse, core input, keystream push and feedback update.
    always_comb begin
        core_start_d = 1'b0;
        core_in_d    = core_in_q;
        ks_push      = 1'b0;
        fb_d         = fb_q;
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_RUN) begin
                    core_start_d = 1'b1;
                    core_in_d    = fb_q;
                end
            end
            ST_RUN: begin
                if (core_done && !load_IV) begin
                    ks_push = 1'b1;
                    fb_d    = core_out;
                end
            end
            default: ;
        endcase
        // A fresh IV replaces the feedback; a result finishing alongside it is dropped.
        if (load_IV) begin
            fb_d = IV;
        end
    end

    // Core interface and feedback registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_prev_q  <= 1'b0;
            core_start_q <= 1'b0;
            core_in_q    <= '0;
            fb_q         <= '0;
        end else begin
            busy_prev_q  <= core_busy;
            core_start_q <= core_start_d;
            core_in_q    <= core_in_d;
            fb_q         <= fb_d;
        end
    end

    // Output word, block counter and IV-loaded flag next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        blk_cnt_d   = blk_cnt_q;
        iv_loaded_d = iv_loaded_q | load_IV;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ofb_xor(in_data, ks_head);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (load_IV) begin
            blk_cnt_d = '0;
        end else if (in_xfer) begin
            blk_cnt_d = blk_cnt_q + 32'd1;
        end
    end

    // Output word, block counter and IV-loaded registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            blk_cnt_q   <= '0;
            iv_loaded_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            blk_cnt_q   <= blk_cnt_d;
            iv_loaded_q <= iv_loaded_d;
        end
    end

endmodule

// File: tb/tb_gost89_ofb_sched.sv
// Bench for gost89_ofb_sched. The ECB core is a behavioural stand-in with a
// random multi-cycle latency; the reference model is plain OFB arithmetic:
// S0 = IV, Si = E(Si-1), out_i = in_i ^ Si.
module tb_gost89_ofb_sched;
    import gost89_pkg::*;

    localparam logic [63:0] IV_A     = 64'hd5a8_a608_f4f1_15b4;
    localparam logic [63:0] IV_B     = 64'h0123_4567_89ab_cdef;
    localparam int          MAX_WAIT = 400;
    localparam logic [31:0] KEY_W [8] = '{32'h0475f6e0, 32'h5038fcd7, 32'h9e2c6a1b, 32'h38e57d11,
                                          32'hb41d09f2, 32'h7c63aa58, 32'h1fe29c04, 32'hd2bcefbd};

    // Clock / reset and DUT signals
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_IV, in_valid, out_ready;
    logic [63:0] IV, in_data;
    logic        in_ready, out_valid, core_start, iv_loaded;
    logic [63:0] out_data, core_in;
    logic [63:0] core_out;
    logic        core_busy;
    logic [31:0] blk_cnt;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    gost89_ofb_sched dut (
        .clk(clk), .reset(reset), .load_IV(load_IV), .IV(IV),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_start(core_start), .core_in(core_in), .core_out(core_out), .core_busy(core_busy),
        .iv_loaded(iv_loaded), .blk_cnt(blk_cnt), .dbg_state(dbg_state)
    );

    // Scoreboard state
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_starts = 0;
    logic [63:0] model_s = '0;
    logic [31:0] model_cnt = '0;
    logic [63:0] ct [8];
    logic        saw_start = 1'b0;

    // Stand-in block cipher: small keyed Feistel network.
    function automatic logic [63:0] cipher(input logic [63:0] x);
        logic [31:0] l, r, t;
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 8; i++) begin
            t = r + KEY_W[i];
            t = {t[20:0], t[31:21]} ^ (t * 32'h9E37_79B1);
            t = l ^ t;
            l = r;
            r = t;
        end
        return {r, l};
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    // Behavioural ECB core, reset by the same net as the DUT.
    int          core_left;
    logic [63:0] core_hold;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_busy <= 1'b0;
            core_left <= 0;
            core_out  <= '0;
            core_hold <= '0;
        end else if (core_busy) begin
            if (core_left <= 1) begin
                core_busy <= 1'b0;
                core_out  <= cipher(core_hold);
            end else begin
                core_left <= core_left - 1;
            end
        end else if (core_start) begin
            core_busy <= 1'b1;
            core_hold <= core_in;
            core_left <= $urandom_range(14, 30);
        end
    end

    // Monitor: output ordering/data, output hold, core start rules.
    logic        hold_pend = 1'b0;
    logic [63:0] hold_data = '0;
    logic        busy_prev_tb = 1'b0;
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            hold_pend    = 1'b0;
            busy_prev_tb = 1'b0;
        end else begin
            if (hold_pend) begin
                check1("out_hold_valid", out_valid, 1'b1);
                check("out_hold_data", out_data, hold_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h expected no output", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (core_start) begin
                n_starts++;
                check1("start_while_busy", core_busy || busy_prev_tb, 1'b0);
                check1("start_without_iv", iv_loaded, 1'b1);
            end
            busy_prev_tb = core_busy;
        end
    end

    // Driver: one cycle of stimulus starting at a falling edge.
    task automatic drive_cycle(input logic ld, input logic [63:0] ivv, input logic v,
                               input logic [63:0] d, input logic rdy, input logic ovr,
                               input logic [63:0] ovr_val, output logic took);
        load_IV   = ld;
        IV        = ivv;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
        took      = v && in_ready;
        saw_start = core_start;
        if (ld) check1("ready_during_load", in_ready, 1'b0);
        if (took) begin
            model_s   = cipher(model_s);
            model_cnt = model_cnt + 32'd1;
            exp_q.push_back(ovr ? ovr_val : (d ^ model_s));
        end
        if (ld) begin
            model_s   = ivv;
            model_cnt = '0;
            n_starts  = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic took;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, '0, rdy, 1'b0, '0, took);
    endtask

    task automatic load(input logic [63:0] ivv, input logic rdy);
        logic took;
        drive_cycle(1'b1, ivv, 1'b0, '0, rdy, 1'b0, '0, took);
    endtask

    task automatic send(input logic [63:0] d, input logic ovr, input logic [63:0] ovr_val,
                        input logic rnd_rdy);
        logic took;
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive_cycle(1'b0, '0, 1'b1, d, rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1,
                        ovr, ovr_val, took);
            if (took) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no in_ready expected accept within %0d cycles", MAX_WAIT);
    endtask

    task automatic drain();
        for (int i = 0; i < MAX_WAIT && exp_q.size() != 0; i++) idle(1, 1'b1);
        idle(1, 1'b1);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_start(input logic rdy);
        for (int i = 0; i < MAX_WAIT; i++) begin
            idle(1, rdy);
            if (saw_start) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL start_timeout: got no core_start expected one within %0d cycles", MAX_WAIT);
    endtask

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: got running expected finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic took;
        int   acc;
        load_IV = 1'b0; IV = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 64'h0);
        check1("rst_core_start", core_start, 1'b0);
        check("rst_core_in", core_in, 64'h0);
        check1("rst_iv_loaded", iv_loaded, 1'b0);
        check("rst_blk_cnt", 64'(blk_cnt), 64'h0);
        check1("rst_in_ready", in_ready, 1'b0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // Input offered with no IV: never accepted, core never started
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0, '0, took);
            check1("no_iv_accept", took, 1'b0);
        end
        check("no_iv_starts", 64'(n_starts), 64'd0);
        check1("no_iv_loaded", iv_loaded, 1'b0);

        // Keystream from IV_A with zero plaintext
        load(IV_A, 1'b1);
        check1("iv_loaded_set", iv_loaded, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(64'h0, 1'b0, '0, 1'b0);
            ct[i] = model_s;
        end
        drain();
        check("blk_cnt_after_8", 64'(blk_cnt), 64'(model_cnt));

        // Decryption round trip: ciphertext back in after reloading IV_A
        idle(100, 1'b1);
        load(IV_A, 1'b1);
        check("blk_cnt_cleared", 64'(blk_cnt), 64'h0);
        for (int i = 0; i < 8; i++) send(ct[i], 1'b1, 64'h0, 1'b1);
        drain();
        check("blk_cnt_roundtrip", 64'(blk_cnt), 64'd8);

        // Backpressure: one output held, buffer fills to two, core stops
        idle(100, 1'b1);
        load({$urandom, $urandom}, 1'b1);
        acc = 0;
        for (int i = 0; i < 240; i++) begin
            drive_cycle(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, '0, took);
            if (took) acc++;
        end
        check("hold_accepts", 64'(acc), 64'd1);
        check("hold_starts", 64'(n_starts), 64'd3);
        check1("hold_out_valid", out_valid, 1'b1);

        // Reload 12 cycles into a run, with an output word pending
        drive_cycle(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0, '0, took);
        check1("refill_accept", took, 1'b1);
        wait_start(1'b0);
        idle(11, 1'b0);
        load(IV_B, 1'b0);
        check("reload_drain_state", 64'(dbg_state), 64'(ST_DRAIN));
        idle(5, 1'b0);
        for (int i = 0; i < 4; i++) send({$urandom, $urandom}, 1'b0, '0, 1'b1);
        drain();
        check("blk_cnt_reload", 64'(blk_cnt), 64'(model_cnt));

        // Random traffic with occasional reloads
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 49) == 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                        {$urandom, $urandom}, $urandom_range(0, 3) != 0, 1'b0, '0, took);
        end
        drain();
        check("blk_cnt_random", 64'(blk_cnt), 64'(model_cnt));

        // Reset mid-run, then restart from IV_A
        load({$urandom, $urandom}, 1'b1);
        wait_start(1'b1);
        idle(5, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("inrst_outs", {out_valid, core_start, iv_loaded, in_ready, out_data[59:0]}, 64'h0);
            check("inrst_core_in", core_in, 64'h0);
            check("inrst_blk_cnt", 64'(blk_cnt), 64'h0);
            @(negedge clk);
        end
        exp_q.delete();
        model_cnt = '0;
        n_starts  = 0;
        reset     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, '0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0, '0, took);
            check1("post_rst_accept", took, 1'b0);
        end
        check("post_rst_starts", 64'(n_starts), 64'd0);
        load(IV_A, 1'b1);
        for (int i = 0; i < 8; i++) send(64'h0, 1'b1, ct[i], 1'b1);
        drain();

        // Counter wrap: preset near the top, stream must continue unchanged
        idle(5, 1'b1);
        force dut.blk_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.blk_cnt_q;
        model_cnt = 32'hFFFF_FFFE;
        idle(1, 1'b1);
        check("blk_cnt_preset", 64'(blk_cnt), 64'(model_cnt));
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom}, 1'b0, '0, 1'b0);
            check("blk_cnt_wrap", 64'(blk_cnt), 64'(model_cnt));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
